// File: rtl/frequency_analyzer_pkg.sv
// rtl/frequency_analyzer_pkg.sv - shared register-bank constants and scheduler state encoding
package frequency_analyzer_pkg;

   localparam logic [1:0] REGISTER_NOP             = 2'd0;
   localparam logic [1:0] REGISTER_WRITE_OPERATION = 2'd2;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_CLEAR   = 3'd1,
      ST_MEASURE = 3'd2,
      ST_SETTLE  = 3'd3,
      ST_WRITE   = 3'd4,
      ST_HOLD    = 3'd5,
      ST_DONE    = 3'd6
   } sched_state_e;

   // A zero-length window would never let the analyzers see a pixel, so it is promoted to one clock.
   function automatic logic [31:0] window_length(input logic [31:0] requested);
      return (requested == 32'd0) ? 32'd1 : requested;
   endfunction

endpackage

// File: rtl/analysis_window_timer.sv
// rtl/analysis_window_timer.sv - loadable 32-bit down-counter; done marks the last cycle of a loaded interval
module analysis_window_timer (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        load_i,
   input  logic [31:0] load_value_i,
   output logic        done_o
);

   logic [31:0] count_q;
   logic [31:0] count_d;

   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = load_value_i;
      end else if (count_q != 32'd0) begin
         count_d = count_q - 32'd1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_q <= 32'd0;
      end else begin
         count_q <= count_d;
      end
   end

   // Loaded with N on the cycle before the interval starts, so the Nth cycle sees a count of one.
   assign done_o = (count_q == 32'd1);

endmodule

// File: rtl/frequency_analysis_scheduler.sv
// rtl/frequency_analysis_scheduler.sv - sequences clear/measure/settle, then publishes snapshotted results
module frequency_analysis_scheduler
   import frequency_analyzer_pkg::*;
#(
   parameter int NUM_CHANNELS  = 6,
   parameter int CLEAR_CYCLES  = 4,
   parameter int SETTLE_CYCLES = 4,
   parameter int HOLD_CYCLES   = 3
) (
   input  logic                      s00_axi_aclk,
   input  logic                      s00_axi_aresetn,
   input  logic                      arm,
   input  logic                      abort,
   input  logic                      irq_ack,
   input  logic [31:0]               window_cycles,
   input  logic [NUM_CHANNELS*32-1:0] result_data,
   output logic                      analyzer_enable,
   output logic                      analyzer_clear,
   output logic [1:0]                register_operation,
   output logic [7:0]                register_number,
   output logic [31:0]               register_write,
   output logic                      irq,
   output logic                      busy,
   output logic                      overrun
);

   localparam int IDX_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHANNELS - 1);

   sched_state_e     state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [31:0]      window_q;
   logic             overrun_q;
   logic [31:0]      snapshot_q [NUM_CHANNELS];

   logic        timer_load;
   logic [31:0] timer_value;
   logic        timer_done;
   logic        accept_arm;
   logic        capture;

   analysis_window_timer u_timer (
      .clk_i        (s00_axi_aclk),
      .rst_ni       (s00_axi_aresetn),
      .load_i       (timer_load),
      .load_value_i (timer_value),
      .done_o       (timer_done)
   );

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      timer_load  = 1'b0;
      timer_value = 32'd0;
      accept_arm  = 1'b0;
      capture     = 1'b0;
      case (state_q)
         ST_IDLE:    if (arm) accept_arm = 1'b1;
         ST_CLEAR:   if (timer_done) begin
                        state_d     = ST_MEASURE;
                        timer_load  = 1'b1;
                        timer_value = window_q;
                     end
         ST_MEASURE: if (timer_done) begin
                        state_d     = ST_SETTLE;
                        timer_load  = 1'b1;
                        timer_value = 32'(SETTLE_CYCLES);
                     end
         ST_SETTLE:  if (timer_done) begin
                        state_d = ST_WRITE;
                        idx_d   = '0;
                        capture = 1'b1;
                     end
         ST_WRITE:   if (HOLD_CYCLES != 0) begin
                        state_d     = ST_HOLD;
                        timer_load  = 1'b1;
                        timer_value = 32'(HOLD_CYCLES);
                     end else if (idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                     end else begin
                        idx_d = idx_q + IDX_W'(1);
                     end
         ST_HOLD:    if (timer_done) begin
                        if (idx_q == LAST_IDX) begin
                           state_d = ST_DONE;
                        end else begin
                           state_d = ST_WRITE;
                           idx_d   = idx_q + IDX_W'(1);
                        end
                     end
         ST_DONE:    if (arm) accept_arm = 1'b1;
                     else if (irq_ack) state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase

      // abort beats a simultaneous arm, including the implicit re-arm from DONE
      if (abort) begin
         accept_arm = 1'b0;
         capture    = 1'b0;
         timer_load = 1'b0;
         state_d    = ST_IDLE;
      end
      if (accept_arm) begin
         state_d     = ST_CLEAR;
         timer_load  = 1'b1;
         timer_value = 32'(CLEAR_CYCLES);
      end
   end

   always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
      if (!s00_axi_aresetn) begin
         state_q   <= ST_IDLE;
         idx_q     <= '0;
         window_q  <= 32'd0;
         overrun_q <= 1'b0;
         for (int k = 0; k < NUM_CHANNELS; k++) snapshot_q[k] <= 32'd0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         if (accept_arm) begin
            window_q  <= window_length(window_cycles);
            overrun_q <= 1'b0;
         end else if (arm && busy && !abort) begin
            overrun_q <= 1'b1;
         end
         if (capture) begin
            for (int k = 0; k < NUM_CHANNELS; k++) snapshot_q[k] <= result_data[32*k +: 32];
         end
      end
   end

   always_comb begin
      register_operation = REGISTER_NOP;
      register_number    = 8'd0;
      register_write     = 32'd0;
      if (state_q == ST_WRITE) register_operation = REGISTER_WRITE_OPERATION;
      if (state_q == ST_WRITE || state_q == ST_HOLD) begin
         register_number = 8'(idx_q) + 8'd1;
         register_write  = snapshot_q[idx_q];
      end
   end

   assign analyzer_enable = (state_q == ST_MEASURE);
   assign analyzer_clear  = (state_q == ST_CLEAR);
   assign irq             = (state_q == ST_DONE);
   assign busy            = (state_q != ST_IDLE) && (state_q != ST_DONE);
   assign overrun         = overrun_q;

endmodule
